// File: rtl/bky_load_arb_if.sv
// Handshake bundle between the config/JTAG requesters, the load FIFO status and the buckeye loader.
// Latency: none (wires only).
// Backpressure: none here; the arbiter paces the requesters through gnt/done/err.
//
// Ports (signals):
//   req[1:0]        level load requests (bit0 power-up, bit1 JTAG)
//   word_cnt        load-FIFO occupancy
//   set_done        loader done flag
//   clr_err         one-cycle pulse clearing err_flag
//   gnt[1:0]        one-hot grant
//   bky_start       loader START
//   bky_rst         loader reset pulse
//   busy            arbiter not idle
//   done[1:0]       completion pulse to the granted requester
//   err[1:0]        error pulse to the granted requester
//   err_flag        sticky error
//   load_cnt[7:0]   saturating count of successful loads
interface bky_load_arb_if #(
  parameter int CNT_W = 6
);
  logic [1:0]       req;
  logic [CNT_W-1:0] word_cnt;
  logic             set_done;
  logic             clr_err;
  logic [1:0]       gnt;
  logic             bky_start;
  logic             bky_rst;
  logic             busy;
  logic [1:0]       done;
  logic [1:0]       err;
  logic             err_flag;
  logic [7:0]       load_cnt;

  // System side: requesters, FIFO status and loader feedback.
  modport master (
    output req, word_cnt, set_done, clr_err,
    input  gnt, bky_start, bky_rst, busy, done, err, err_flag, load_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, word_cnt, set_done, clr_err,
    output gnt, bky_start, bky_rst, busy, done, err, err_flag, load_cnt
  );
endinterface

// File: rtl/bky_load_arb.sv
// Arbitrates the buckeye shift-chain loader between power-up auto-load [0] and JTAG load [1], with watchdogs.
// Latency: req in IDLE with enough FIFO words -> bky_start high after 3 clk edges (GRANT, WAIT_DATA, RUN).
// Backpressure: requests wait in IDLE while busy; WAIT_DATA stalls until word_cnt >= NWORDS or timeout.
//
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    bky_load_arb_if.slave (requests, FIFO level, loader handshake, status outputs)
module bky_load_arb #(
  parameter int NWORDS   = 19,
  parameter int CNT_W    = 6,
  parameter int TMO      = 4000,
  parameter int TMO_W    = 16,
  parameter int BRST_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bky_load_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] NWORDS_C  = CNT_W'(NWORDS);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO - 1);
  localparam logic [TMO_W-1:0] BRST_LAST = TMO_W'(BRST_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_DATA,
    S_RUN,
    S_RELEASE,
    S_COMPLETE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] timer;
  logic             last_gnt;   // index of the requester served most recently

  logic [1:0] pick;
  logic       data_ok;
  logic       wd_exp;
  logic       to_error;

  // Round-robin only matters when both request; a lone request always wins.
  always_comb begin
    pick = bus.req;
    if (bus.req == 2'b11) begin
      pick = last_gnt ? 2'b01 : 2'b10;
    end
  end

  assign data_ok = (bus.word_cnt >= NWORDS_C);
  assign wd_exp  = (timer == TMO_LAST);

  // A watchdog phase only errors when its own exit condition is not met in the same cycle.
  always_comb begin
    to_error = 1'b0;
    if (wd_exp) begin
      case (state)
        S_WAIT_DATA: to_error = !data_ok;
        S_RUN:       to_error = !bus.set_done;
        S_RELEASE:   to_error = bus.set_done;
        default:     to_error = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      timer         <= '0;
      last_gnt      <= 1'b1;
      bus.gnt       <= 2'b00;
      bus.bky_start <= 1'b0;
      bus.bky_rst   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 2'b00;
      bus.err       <= 2'b00;
      bus.err_flag  <= 1'b0;
      bus.load_cnt  <= 8'd0;
    end else begin
      bus.done <= 2'b00;
      bus.err  <= 2'b00;
      // Saturating: the timer parks at TMO-1 instead of wrapping (e.g. a long IDLE).
      timer    <= wd_exp ? timer : timer + 1'b1;

      // An error entry later in this block overrides the clear.
      if (bus.clr_err) begin
        bus.err_flag <= 1'b0;
      end

      if (to_error) begin
        state         <= S_ERROR;
        timer         <= '0;
        bus.bky_start <= 1'b0;
        bus.bky_rst   <= 1'b1;
        bus.err       <= bus.gnt;
        bus.err_flag  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.req != 2'b00) begin
              state    <= S_GRANT;
              timer    <= '0;
              bus.gnt  <= pick;
              bus.busy <= 1'b1;
            end
          end
          S_GRANT: begin
            last_gnt <= bus.gnt[1];
            state    <= S_WAIT_DATA;
            timer    <= '0;
          end
          S_WAIT_DATA: begin
            if (data_ok) begin
              state         <= S_RUN;
              timer         <= '0;
              bus.bky_start <= 1'b1;
            end
          end
          S_RUN: begin
            if (bus.set_done) begin
              state         <= S_RELEASE;
              timer         <= '0;
              bus.bky_start <= 1'b0;
            end
          end
          S_RELEASE: begin
            if (!bus.set_done) begin
              state    <= S_COMPLETE;
              timer    <= '0;
              bus.done <= bus.gnt;
              if (bus.load_cnt != 8'hFF) begin
                bus.load_cnt <= bus.load_cnt + 8'd1;
              end
            end
          end
          S_COMPLETE: begin
            state    <= S_IDLE;
            timer    <= '0;
            bus.gnt  <= 2'b00;
            bus.busy <= 1'b0;
          end
          S_ERROR: begin
            if (timer == BRST_LAST) begin
              state       <= S_IDLE;
              timer       <= '0;
              bus.bky_rst <= 1'b0;
              bus.gnt     <= 2'b00;
              bus.busy    <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            timer <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bky_load_arb.sv
module tb_bky_load_arb;

  localparam int NWORDS = 19;
  localparam int TMO    = 4000;
  localparam int BRST   = 4;

  logic clk;
  logic rst_n;

  bky_load_arb_if #(.CNT_W(6)) bus ();

  bky_load_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: who was served last, and the expected success count.
  int model_last = 1;
  int model_cnt  = 0;
  bit gnt_both   = 1'b0;

  always @(negedge clk) begin
    if (bus.gnt === 2'b11) gnt_both = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] r);
    if (r == 2'b11) return (model_last == 1) ? 2'b01 : 2'b10;
    return r;
  endfunction

  // One successful load: request, grant, START, loader raises done after dly
  // cycles, holds it rel cycles after START drops, then completion.
  task automatic run_load(input logic [1:0] r, input int dly, input int rel, input bit keep);
    logic [1:0] g;
    g = exp_grant(r);
    bus.req      = r;
    bus.word_cnt = 6'($urandom_range(NWORDS, 63));
    bus.set_done = 1'b0;
    step();
    chk("grant", 32'(bus.gnt), 32'(g));
    chk("busy_on", 32'(bus.busy), 32'd1);
    model_last = g[1] ? 1 : 0;
    step();
    chk("start_cyc2", 32'(bus.bky_start), 32'd0);
    step();
    chk("start_cyc3", 32'(bus.bky_start), 32'd1);
    if (!keep) bus.req = 2'b00;
    repeat (dly) step();
    chk("start_hold", 32'(bus.bky_start), 32'd1);
    bus.set_done = 1'b1;
    step();
    chk("start_fall", 32'(bus.bky_start), 32'd0);
    repeat (rel) step();
    chk("no_early_done", 32'(bus.done), 32'd0);
    bus.set_done = 1'b0;
    step();
    chk("done_pulse", 32'(bus.done), 32'(g));
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    chk("load_cnt", 32'(bus.load_cnt), 32'(model_cnt));
    step();
    chk("gnt_clear", 32'(bus.gnt), 32'd0);
    chk("done_clear", 32'(bus.done), 32'd0);
    chk("busy_off", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cycles;
    int start_hi;
    int rst_hi;
    int err_hi;
    logic [1:0] rr;

    rst_n        = 1'b0;
    bus.req      = 2'b00;
    bus.word_cnt = '0;
    bus.set_done = 1'b0;
    bus.clr_err  = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_start", 32'(bus.bky_start), 32'd0);
    chk("rst_bkyrst", 32'(bus.bky_rst), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_errflag", 32'(bus.err_flag), 32'd0);
    chk("rst_loadcnt", 32'(bus.load_cnt), 32'd0);
    rst_n = 1'b1;
    step();

    // Power-up load, loader answers 330 cycles after START
    run_load(2'b01, 330, 2, 1'b0);

    // Asynchronous reset in the middle of RUN
    bus.req      = 2'b01;
    bus.word_cnt = 6'(NWORDS);
    repeat (3) step();
    chk("pre_rst_start", 32'(bus.bky_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_start", 32'(bus.bky_start), 32'd0);
    chk("arst_gnt", 32'(bus.gnt), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_loadcnt", 32'(bus.load_cnt), 32'd0);
    step();
    rst_n      = 1'b1;
    model_last = 1;
    model_cnt  = 0;

    // Both requesting for three loads: expect 0, 1, 0
    run_load(2'b11, $urandom_range(0, 20), $urandom_range(1, 3), 1'b1);
    chk("rr_first", 32'(model_last), 32'd0);
    run_load(2'b11, $urandom_range(0, 20), $urandom_range(1, 3), 1'b1);
    chk("rr_second", 32'(model_last), 32'd1);
    run_load(2'b11, $urandom_range(0, 20), $urandom_range(1, 3), 1'b1);
    bus.req = 2'b00;
    step();
    chk("idle_after_rr", 32'(bus.busy), 32'd0);

    // WAIT_DATA watchdog: FIFO never fills
    bus.req      = 2'b10;
    bus.word_cnt = 6'd10;
    step();
    chk("wd_grant", 32'(bus.gnt), 32'd2);
    model_last = 1;
    bus.req    = 2'b00;
    cycles     = 1;
    start_hi   = 0;
    while (bus.err === 2'b00 && cycles < TMO + 100) begin
      step();
      cycles++;
      if (bus.bky_start === 1'b1) start_hi++;
    end
    chk("wd_cycles", 32'(cycles), 32'(2 + TMO));
    chk("wd_err", 32'(bus.err), 32'd2);
    chk("wd_errflag", 32'(bus.err_flag), 32'd1);
    rst_hi = 0;
    err_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.bky_rst === 1'b1) rst_hi++;
      if (bus.err !== 2'b00) err_hi++;
      step();
    end
    chk("wd_bkyrst_len", 32'(rst_hi), 32'(BRST));
    chk("wd_err_len", 32'(err_hi), 32'd1);
    chk("wd_start_never", 32'(start_hi), 32'd0);
    chk("wd_idle", 32'(bus.gnt), 32'd0);
    chk("wd_flag_sticky", 32'(bus.err_flag), 32'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("clr_err", 32'(bus.err_flag), 32'd0);

    // RUN watchdog: SET_DONE stuck low; CLR_ERR collides with the error entry
    bus.req      = 2'b01;
    bus.word_cnt = 6'(NWORDS);
    bus.set_done = 1'b0;
    step();
    chk("run_wd_grant", 32'(bus.gnt), 32'd1);
    model_last = 0;
    bus.req    = 2'b00;
    step();
    step();
    chk("run_wd_start", 32'(bus.bky_start), 32'd1);
    repeat (TMO - 1) step();
    chk("run_wd_start_late", 32'(bus.bky_start), 32'd1);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    chk("run_wd_err", 32'(bus.err), 32'd1);
    chk("run_wd_set_wins", 32'(bus.err_flag), 32'd1);
    chk("run_wd_start_fall", 32'(bus.bky_start), 32'd0);
    chk("run_wd_bkyrst", 32'(bus.bky_rst), 32'd1);
    chk("run_wd_loadcnt", 32'(bus.load_cnt), 32'(model_cnt));
    repeat (BRST) step();
    chk("run_wd_idle", 32'(bus.busy), 32'd0);

    // Request dropped in RUN still completes; then saturate the load counter
    run_load(2'b01, 5, 1, 1'b0);
    for (int k = 0; k < 256; k++) begin
      rr = 2'($urandom_range(1, 3));
      run_load(rr, $urandom_range(0, 4), $urandom_range(1, 3), 1'b0);
    end
    chk("sat_loadcnt", 32'(bus.load_cnt), 32'd255);
    chk("gnt_never_both", 32'(gnt_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
